multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 2, ALU-op field width. Codes: R-type 2'b10, add 2'b01, sub 2'b00, zero-extended to ALUOP_W.
REQ-003 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-004 SHALL have opcode parameters OP_R=4, OP_ADDIU=12, OP_SUBIU=13, OP_SW=16, OP_LW=17, OP_BEQ=19, OP_J=28.
REQ-005 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 opcode  input  OPCODE_W  instruction opcode, sampled in DECODE.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-010 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-011 pc_write, ir_write, reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg  output  1 each  datapath enables and selects.
REQ-012 alu_op  output  ALUOP_W  ALU operation class.
REQ-013 pc_src  output  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-014 illegal  output  1  sticky flag: an undefined opcode was decoded.
REQ-015 retired  output  CNT_W  count of completed instructions.

Function
REQ-016 Outputs SHALL be combinational decodes of state, the latched opcode op_q, mem_ready and zero only.
REQ-017 Outputs not asserted by the current state SHALL be 0. Exception: alu_op = add outside EXEC.
REQ-018 FETCH
- mem_read=1 every cycle.
- When mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
- Otherwise: remain in FETCH with pc_write=ir_write=0.
REQ-019 DECODE
- Latch opcode into op_q.
- OP_J: pc_write=1, pc_src=2; next FETCH; retired increments.
- Any other defined opcode: next EXEC.
- Undefined opcode: next TRAP; set illegal.
REQ-020 EXEC alu_op: OP_R -> 10; ADDIU/LW/SW -> add; SUBIU/BEQ -> sub.
REQ-021 EXEC alu_src: 1 for ADDIU, SUBIU, LW, SW; 0 for OP_R and OP_BEQ.
REQ-022 EXEC next state
- OP_BEQ: pc_write=zero, pc_src=1; next FETCH; retired increments.
- LW/SW: next MEM.
- Otherwise: next WB.
REQ-023 MEM
- LW asserts mem_read; SW asserts mem_write; held until mem_ready=1.
- On mem_ready: SW goes to FETCH and retired increments; LW goes to WB.
REQ-024 WB
- reg_write=1 for exactly one cycle.
- reg_dst=1 for OP_R, else 0.
- mem_to_reg=1 for LW, else 0.
- Next FETCH; retired increments.
REQ-025 TRAP SHALL hold all enables at 0 and remain in TRAP until rst.
REQ-026 Latencies with mem_ready tied high: J 2, BEQ 3, R/ADDIU/SUBIU 4, SW 4, LW 5 cycles. Each wait cycle adds 1.
REQ-027 retired SHALL increment by exactly 1 per completed instruction and wrap from 2^CNT_W-1 to 0.
REQ-028 A change of opcode outside DECODE SHALL NOT affect the current instruction.
REQ-029 mem_ready SHALL be ignored in DECODE, EXEC, WB and TRAP.

Reset
REQ-030 While rst=1, and asynchronously on its assertion, the block SHALL force: state=FETCH, op_q=0, illegal=0, retired=0.
REQ-031 Assertion of rst mid-instruction SHALL abandon that instruction without incrementing retired.
REQ-032 In the first cycle after rst deasserts, mem_read=1 and all other enables=0.

Verification
REQ-033 With mem_ready=1, the sequence R, ADDIU, LW, SW -> states 0-1-2-4, 0-1-2-4, 0-1-2-3-4, 0-1-2-3; reg_write pulses 3; retired=4.
REQ-034 BEQ with zero=1, then BEQ with zero=0 -> pc_write=1/pc_src=1 in the first EXEC only; retired=2.
REQ-035 LW with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles in MEM; WB one cycle later; total 8 cycles.
REQ-036 Opcode 6'd63 in DECODE -> TRAP and illegal=1, held for 10 cycles; rst -> FETCH with illegal=0.
REQ-037 CNT_W=2, five J instructions -> retired sequence 1,2,3,0,1.
REQ-038 rst pulsed mid-MEM of SW -> mem_write drops immediately; state=FETCH; retired unchanged at 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                zero;
  logic [2:0]          state;
  logic                pc_write;
  logic                ir_write;
  logic                reg_write;
  logic                reg_dst;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_src;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, mem_ready, zero,
    output state, pc_write, ir_write, reg_write, reg_dst, alu_src, mem_read,
           mem_write, mem_to_reg, alu_op, pc_src, illegal, retired
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  state, pc_write, ir_write, reg_write, reg_dst, alu_src, mem_read,
           mem_write, mem_to_reg, alu_op, pc_src, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky
// illegal-opcode trap and a wrapping retired-instruction counter.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16,
  parameter int OP_R     = 4,
  parameter int OP_ADDIU = 12,
  parameter int OP_SUBIU = 13,
  parameter int OP_SW    = 16,
  parameter int OP_LW    = 17,
  parameter int OP_BEQ   = 19,
  parameter int OP_J     = 28
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OPC_R     = OPCODE_W'(OP_R);
  localparam logic [OPCODE_W-1:0] OPC_ADDIU = OPCODE_W'(OP_ADDIU);
  localparam logic [OPCODE_W-1:0] OPC_SUBIU = OPCODE_W'(OP_SUBIU);
  localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);

  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b00);

  function automatic logic isDefined(input logic [OPCODE_W-1:0] op);
    return (op == OPC_R) || (op == OPC_ADDIU) || (op == OPC_SUBIU) || (op == OPC_SW) ||
           (op == OPC_LW) || (op == OPC_BEQ) || (op == OPC_J);
  endfunction

  state_t              state_r;
  state_t              nextState_s;
  logic [OPCODE_W-1:0] opQ_r;
  logic [OPCODE_W-1:0] curOp_s;
  logic                illegal_r;
  logic [CNT_W-1:0]    retired_r;
  logic                retire_s;
  logic                setIllegal_s;
  logic                pcWrite_s;
  logic                irWrite_s;
  logic                regWrite_s;
  logic                regDst_s;
  logic                aluSrc_s;
  logic                memRead_s;
  logic                memWrite_s;
  logic                memToReg_s;
  logic [ALUOP_W-1:0]  aluOp_s;
  logic [1:0]          pcSrc_s;

  // In DECODE the opcode is decoded as it is being latched, so a J can redirect the PC that cycle.
  assign curOp_s = (state_r == DECODE) ? bus.opcode : opQ_r;

  // Next-state and control decode from state, latched opcode, mem_ready and zero.
  always_comb begin
    nextState_s  = state_r;
    retire_s     = 1'b0;
    setIllegal_s = 1'b0;
    pcWrite_s    = 1'b0;
    irWrite_s    = 1'b0;
    regWrite_s   = 1'b0;
    regDst_s     = 1'b0;
    aluSrc_s     = 1'b0;
    memRead_s    = 1'b0;
    memWrite_s   = 1'b0;
    memToReg_s   = 1'b0;
    aluOp_s      = ALU_ADD;
    pcSrc_s      = 2'd0;
    case (state_r)
      FETCH: begin
        memRead_s = 1'b1;
        if (bus.mem_ready) begin
          irWrite_s   = 1'b1;
          pcWrite_s   = 1'b1;
          nextState_s = DECODE;
        end else begin
          nextState_s = FETCH;
        end
      end
      DECODE: begin
        if (curOp_s == OPC_J) begin
          pcWrite_s   = 1'b1;
          pcSrc_s     = 2'd2;
          retire_s    = 1'b1;
          nextState_s = FETCH;
        end else if (isDefined(curOp_s)) begin
          nextState_s = EXEC;
        end else begin
          setIllegal_s = 1'b1;
          nextState_s  = TRAP;
        end
      end
      EXEC: begin
        if (curOp_s == OPC_R) begin
          aluOp_s = ALU_RTYPE;
        end else if ((curOp_s == OPC_SUBIU) || (curOp_s == OPC_BEQ)) begin
          aluOp_s = ALU_SUB;
        end else begin
          aluOp_s = ALU_ADD;
        end
        aluSrc_s = (curOp_s == OPC_ADDIU) || (curOp_s == OPC_SUBIU) ||
                   (curOp_s == OPC_LW) || (curOp_s == OPC_SW);
        if (curOp_s == OPC_BEQ) begin
          pcWrite_s   = bus.zero;
          pcSrc_s     = 2'd1;
          retire_s    = 1'b1;
          nextState_s = FETCH;
        end else if ((curOp_s == OPC_LW) || (curOp_s == OPC_SW)) begin
          nextState_s = MEM;
        end else begin
          nextState_s = WB;
        end
      end
      MEM: begin
        memRead_s  = (curOp_s == OPC_LW);
        memWrite_s = (curOp_s == OPC_SW);
        if (!bus.mem_ready) begin
          nextState_s = MEM;
        end else if (curOp_s == OPC_LW) begin
          nextState_s = WB;
        end else begin
          retire_s    = 1'b1;
          nextState_s = FETCH;
        end
      end
      WB: begin
        regWrite_s  = 1'b1;
        regDst_s    = (curOp_s == OPC_R);
        memToReg_s  = (curOp_s == OPC_LW);
        retire_s    = 1'b1;
        nextState_s = FETCH;
      end
      TRAP: begin
        nextState_s = TRAP;
      end
      default: begin
        nextState_s = FETCH;
      end
    endcase
  end

  // State register, opcode latch, sticky illegal flag and retired counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      opQ_r     <= {OPCODE_W{1'b0}};
      illegal_r <= 1'b0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      if (state_r == DECODE) begin
        opQ_r <= bus.opcode;
      end
      if (setIllegal_s) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  assign bus.state      = state_r;
  assign bus.pc_write   = pcWrite_s;
  assign bus.ir_write   = irWrite_s;
  assign bus.reg_write  = regWrite_s;
  assign bus.reg_dst    = regDst_s;
  assign bus.alu_src    = aluSrc_s;
  assign bus.mem_read   = memRead_s;
  assign bus.mem_write  = memWrite_s;
  assign bus.mem_to_reg = memToReg_s;
  assign bus.alu_op     = aluOp_s;
  assign bus.pc_src     = pcSrc_s;
  assign bus.illegal    = illegal_r;
  assign bus.retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into a per-cycle
// script of expected states/controls, then played against two DUTs (CNT_W 16 and 2).
module tb_multicycle_control;

  localparam logic [5:0] OPR = 6'd4, OPADDIU = 6'd12, OPSUBIU = 6'd13, OPSW = 6'd16,
                         OPLW = 6'd17, OPBEQ = 6'd19, OPJ = 6'd28;
  localparam logic [1:0] AADD = 2'b01, ASUB = 2'b00, ARTY = 2'b10;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [5:0]  opc;
    logic        mr;
    logic        z;
    logic        ret;
    logic        ill;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   modelRetired = 0;
  logic modelIllegal = 1'b0;
  int   rwPulses = 0;
  cyc_t script[$];

  multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(16)) ifc();
  multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(2))  ifc2();

  assign ifc2.opcode    = ifc.opcode;
  assign ifc2.mem_ready = ifc.mem_ready;
  assign ifc2.zero      = ifc.zero;

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc));
  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(ifc2));

  always #5 clk = ~clk;

  function automatic logic [11:0] mkCtl(input logic pcw, irw, rw, rdst, asrc, mrd, mwr, m2r,
                                        input logic [1:0] aop, input logic [1:0] psrc);
    return {pcw, irw, rw, rdst, asrc, mrd, mwr, m2r, aop, psrc};
  endfunction

  function automatic logic [11:0] obsCtl();
    return {ifc.pc_write, ifc.ir_write, ifc.reg_write, ifc.reg_dst, ifc.alu_src,
            ifc.mem_read, ifc.mem_write, ifc.mem_to_reg, ifc.alu_op, ifc.pc_src};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [11:0] ctl, input logic [5:0] opc,
                      input logic mr, input logic z, input logic ret, input logic ill);
    cyc_t c;
    c.st = st; c.ctl = ctl; c.opc = opc; c.mr = mr; c.z = z; c.ret = ret; c.ill = ill;
    script.push_back(c);
  endtask

  // Expand one instruction into the cycles it should take, with don't-care inputs randomized.
  task automatic addInstr(input logic [5:0] op, input int fw, input int mw, input logic z);
    logic [11:0] idle;
    logic        known, isLw, isSw, isR, imm;
    logic [1:0]  cls;
    idle  = mkCtl(0, 0, 0, 0, 0, 0, 0, 0, AADD, 2'd0);
    known = (op == OPR) || (op == OPADDIU) || (op == OPSUBIU) || (op == OPSW) ||
            (op == OPLW) || (op == OPBEQ) || (op == OPJ);
    isLw  = (op == OPLW);
    isSw  = (op == OPSW);
    isR   = (op == OPR);
    imm   = (op == OPADDIU) || (op == OPSUBIU) || isLw || isSw;
    cls   = isR ? ARTY : (((op == OPSUBIU) || (op == OPBEQ)) ? ASUB : AADD);
    for (int i = 0; i < fw; i++) push(3'd0, mkCtl(0, 0, 0, 0, 0, 1, 0, 0, AADD, 2'd0), ro(), 1'b0, rb(), 1'b0, 1'b0);
    push(3'd0, mkCtl(1, 1, 0, 0, 0, 1, 0, 0, AADD, 2'd0), ro(), 1'b1, rb(), 1'b0, 1'b0);
    if (!known) begin
      push(3'd1, idle, op, rb(), rb(), 1'b0, 1'b1);
      return;
    end
    if (op == OPJ) begin
      push(3'd1, mkCtl(1, 0, 0, 0, 0, 0, 0, 0, AADD, 2'd2), op, rb(), rb(), 1'b1, 1'b0);
      return;
    end
    push(3'd1, idle, op, rb(), rb(), 1'b0, 1'b0);
    if (op == OPBEQ) begin
      push(3'd2, mkCtl(z, 0, 0, 0, 0, 0, 0, 0, ASUB, 2'd1), ro(), rb(), z, 1'b1, 1'b0);
      return;
    end
    push(3'd2, mkCtl(0, 0, 0, 0, imm, 0, 0, 0, cls, 2'd0), ro(), rb(), rb(), 1'b0, 1'b0);
    if (isLw || isSw) begin
      for (int i = 0; i < mw; i++) push(3'd3, mkCtl(0, 0, 0, 0, 0, isLw, isSw, 0, AADD, 2'd0), ro(), 1'b0, rb(), 1'b0, 1'b0);
      push(3'd3, mkCtl(0, 0, 0, 0, 0, isLw, isSw, 0, AADD, 2'd0), ro(), 1'b1, rb(), isSw, 1'b0);
      if (isSw) return;
    end
    push(3'd4, mkCtl(0, 0, 1, isR, 0, 0, 0, isLw, AADD, 2'd0), ro(), rb(), rb(), 1'b1, 1'b0);
  endtask

  task automatic addTrap(input int n);
    for (int i = 0; i < n; i++) push(3'd5, mkCtl(0, 0, 0, 0, 0, 0, 0, 0, AADD, 2'd0), ro(), rb(), rb(), 1'b0, 1'b0);
  endtask

  // Play up to n scripted cycles (all when n < 0): drive at negedge, check 1 ns later.
  task automatic runCycles(input int n);
    cyc_t c;
    int   k;
    k = 0;
    while ((script.size() > 0) && ((n < 0) || (k < n))) begin
      c = script.pop_front();
      @(negedge clk);
      ifc.opcode = c.opc; ifc.mem_ready = c.mr; ifc.zero = c.z;
      #1;
      chk("state", 32'(ifc.state), 32'(c.st));
      chk("controls", 32'(obsCtl()), 32'(c.ctl));
      chk("retired", 32'(ifc.retired), 32'(modelRetired % 65536));
      chk("retired_w2", 32'(ifc2.retired), 32'(modelRetired % 4));
      chk("illegal", 32'(ifc.illegal), 32'(modelIllegal));
      if (ifc.reg_write) rwPulses++;
      @(posedge clk);
      if (c.ret) modelRetired++;
      if (c.ill) modelIllegal = 1'b1;
      k++;
    end
  endtask

  // Assert rst asynchronously mid-cycle, check the forced state, then release with mem_ready low.
  task automatic applyReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(ifc.state), 32'd0);
    chk("rst_retired", 32'(ifc.retired), 32'd0);
    chk("rst_retired_w2", 32'(ifc2.retired), 32'd0);
    chk("rst_illegal", 32'(ifc.illegal), 32'd0);
    chk("rst_mem_write", 32'(ifc.mem_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    rst = 1'b0;
    script.delete();
    modelRetired = 0;
    modelIllegal = 1'b0;
    #1;
    chk("post_rst_controls", 32'(obsCtl()), 32'(mkCtl(0, 0, 0, 0, 0, 1, 0, 0, AADD, 2'd0)));
  endtask

  initial begin
    logic [5:0] ops [7];
    ops[0] = OPR; ops[1] = OPADDIU; ops[2] = OPSUBIU; ops[3] = OPSW;
    ops[4] = OPLW; ops[5] = OPBEQ; ops[6] = OPJ;
    ifc.opcode = 6'd0; ifc.mem_ready = 1'b0; ifc.zero = 1'b0;
    repeat (2) @(posedge clk);
    applyReset();

    // Five jumps: the 2-bit counter must read 1,2,3,0,1.
    for (int i = 0; i < 5; i++) addInstr(OPJ, 0, 0, 1'b0);
    runCycles(-1);
    #1 chk("j5_retired_w2", 32'(ifc2.retired), 32'd1);

    applyReset();
    rwPulses = 0;
    addInstr(OPR, 0, 0, 1'b0);
    addInstr(OPADDIU, 0, 0, 1'b0);
    addInstr(OPLW, 0, 0, 1'b0);
    addInstr(OPSW, 0, 0, 1'b0);
    runCycles(-1);
    #1 chk("seq_retired", 32'(ifc.retired), 32'd4);
    chk("seq_reg_write_pulses", 32'(rwPulses), 32'd3);

    addInstr(OPBEQ, 0, 0, 1'b1);
    addInstr(OPBEQ, 0, 0, 1'b0);
    addInstr(OPLW, 0, 3, 1'b0);
    addInstr(OPSUBIU, 2, 0, 1'b0);
    runCycles(-1);
    #1 chk("beq_lw_retired", 32'(ifc.retired), 32'd8);

    for (int i = 0; i < 40; i++)
      addInstr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2), rb());
    runCycles(-1);

    // Reset during a stalled SW store must drop mem_write at once.
    applyReset();
    addInstr(OPSW, 0, 3, 1'b0);
    runCycles(4);
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    #1 chk("pre_rst_mem_write", 32'(ifc.mem_write), 32'd1);
    applyReset();

    addInstr(6'd63, 1, 0, 1'b0);
    addTrap(10);
    runCycles(-1);
    applyReset();
    addInstr(OPADDIU, 0, 0, 1'b0);
    runCycles(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
